// File: rtl/vga_timing_gen_if.sv
// Signal bundle between the raster timing generator and the text/DAC logic.
// The generator uses the master modport; the consumer side uses slave.
interface vga_timing_gen_if #(
    parameter int H_WIDTH    = 12,
    parameter int V_WIDTH    = 11,
    parameter int ADDR_WIDTH = 11
);
    logic                  enable;
    logic [3:0]            red_in;
    logic [3:0]            green_in;
    logic [3:0]            blue_in;
    logic [H_WIDTH-1:0]    h_position;
    logic [V_WIDTH-1:0]    v_position;
    logic [ADDR_WIDTH-1:0] cell_addr;
    logic                  pixel_tick;
    logic                  line_start;
    logic                  frame_start;
    logic                  h_sync_out;
    logic                  v_sync_out;
    logic                  display_enable;
    logic [3:0]            red_out;
    logic [3:0]            green_out;
    logic [3:0]            blue_out;

    modport master (
        input  enable, red_in, green_in, blue_in,
        output h_position, v_position, cell_addr, pixel_tick, line_start,
               frame_start, h_sync_out, v_sync_out, display_enable,
               red_out, green_out, blue_out
    );

    modport slave (
        output enable, red_in, green_in, blue_in,
        input  h_position, v_position, cell_addr, pixel_tick, line_start,
               frame_start, h_sync_out, v_sync_out, display_enable,
               red_out, green_out, blue_out
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-clock enable, text-cell
// addressing and a programmable sync/blank delay to match registered font RAM.
module vga_timing_gen #(
    parameter int H_DISPLAY  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_DISPLAY  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int CLK_DIV    = 2,
    parameter int LATENCY    = 0,
    parameter int CELL_SHIFT = 4,
    parameter int COLS       = 40,
    parameter int H_WIDTH    = 12,
    parameter int V_WIDTH    = 11,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    vga_timing_gen_if.master    bus
);
    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam logic [3:0] DIV_MAX = 4'(CLK_DIV - 1);
    localparam logic HS_ACTIVE = 1'(H_SYNC_POL);
    localparam logic VS_ACTIVE = 1'(V_SYNC_POL);

    logic               run_reg;
    logic [3:0]         div_reg;
    logic [H_WIDTH-1:0] h_reg;
    logic [V_WIDTH-1:0] v_reg;
    logic               tick;
    logic               visible;
    logic               hs_raw;
    logic               vs_raw;
    logic [2:0]         delayed;

    // run_reg holds the divider for one clk after release so the first tick
    // lands exactly CLK_DIV cycles after reset/enable, even with CLK_DIV=1.
    assign tick = run_reg && (div_reg == DIV_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg <= 1'b0;
            div_reg <= '0;
            h_reg   <= '0;
            v_reg   <= '0;
        end else if (!bus.enable) begin
            run_reg <= 1'b0;
            div_reg <= '0;
            h_reg   <= '0;
            v_reg   <= '0;
        end else begin
            run_reg <= 1'b1;
            if (run_reg) begin
                div_reg <= (div_reg == DIV_MAX) ? 4'd0 : div_reg + 4'd1;
            end
            if (tick) begin
                if (h_reg == H_WIDTH'(H_TOTAL - 1)) begin
                    h_reg <= '0;
                    v_reg <= (v_reg == V_WIDTH'(V_TOTAL - 1)) ? '0 : v_reg + V_WIDTH'(1);
                end else begin
                    h_reg <= h_reg + H_WIDTH'(1);
                end
            end
        end
    end

    assign visible = (h_reg < H_WIDTH'(H_DISPLAY)) && (v_reg < V_WIDTH'(V_DISPLAY));
    assign hs_raw  = (h_reg >= H_WIDTH'(HS_START)) && (h_reg < H_WIDTH'(HS_END));
    assign vs_raw  = (v_reg >= V_WIDTH'(VS_START)) && (v_reg < V_WIDTH'(VS_END));

    // Stage 0 is the output register itself; LATENCY extra stages follow it.
    // Each stage carries {visible, vs, hs} and advances only on a pixel tick.
    genvar gi;
    generate
        for (gi = 0; gi <= LATENCY; gi++) begin : g_stage
            logic [2:0] stage_reg;
            logic [2:0] stage_in;
            if (gi == 0) begin : g_head
                assign stage_in = {visible, vs_raw, hs_raw};
            end else begin : g_tail
                assign stage_in = g_stage[gi-1].stage_reg;
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_reg <= '0;
                end else if (!bus.enable) begin
                    stage_reg <= '0;
                end else if (tick) begin
                    stage_reg <= stage_in;
                end
            end
        end
    endgenerate

    assign delayed = g_stage[LATENCY].stage_reg;

    assign bus.h_position     = h_reg;
    assign bus.v_position     = v_reg;
    assign bus.pixel_tick     = tick;
    assign bus.line_start     = tick && (h_reg == '0);
    assign bus.frame_start    = tick && (h_reg == '0) && (v_reg == '0);
    assign bus.display_enable = delayed[2];
    assign bus.v_sync_out     = delayed[1] ? VS_ACTIVE : ~VS_ACTIVE;
    assign bus.h_sync_out     = delayed[0] ? HS_ACTIVE : ~HS_ACTIVE;

    assign bus.red_out   = delayed[2] ? bus.red_in   : 4'd0;
    assign bus.green_out = delayed[2] ? bus.green_in : 4'd0;
    assign bus.blue_out  = delayed[2] ? bus.blue_in  : 4'd0;

    // Operands are truncated before the arithmetic; the sum is identical
    // modulo 2^ADDR_WIDTH, which is all the cell address keeps.
    assign bus.cell_addr = visible
        ? ADDR_WIDTH'(h_reg >> CELL_SHIFT)
          + ADDR_WIDTH'(v_reg >> CELL_SHIFT) * ADDR_WIDTH'(COLS)
        : '0;
endmodule
